// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan code decoder.
// Folds E0 (extended) and F0 (break) prefixes into single key events,
// discards keyboard control/response bytes, and queues the resulting
// events in a small first-word-fall-through FIFO for the consumer.
// A pending prefix that is never completed is abandoned after a
// configurable idle period, signalled by a one-cycle timeout pulse.
//
// Event handshake: evt_valid is high whenever the FIFO head holds an
// event, and evt_code/evt_ext/evt_release are stable and meaningful only
// while evt_valid is high (all zero otherwise). The head is consumed on
// any rising clk edge where evt_valid and evt_ready are both high;
// evt_ready while evt_valid is low has no effect. evt_valid never drops
// without a pop except on reset.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       overflow,
    output logic       timeout
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    // State encoding chosen so bit 0 = extended prefix seen, bit 1 = break seen.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [TO_W-1:0]  to_cnt;
    logic             to_fire;
    logic             ev_push;
    logic [9:0]       ev_data;

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             pop;
    logic             wr_en;

    // Byte decode and prefix-abandon decision for the current cycle.
    always_comb begin
        next_state = state;
        ev_push    = 1'b0;
        to_fire    = 1'b0;
        ev_data    = {rx_data, state[0], state[1]};
        if (rx_done) begin
            case (rx_data)
                8'hE0: next_state = S_EXT;
                8'hF0: next_state = state[0] ? S_EXT_BRK : S_BRK;
                8'h00, 8'hAA, 8'hE1, 8'hEE,
                8'hFA, 8'hFC, 8'hFE, 8'hFF: next_state = S_IDLE;
                default: begin
                    ev_push    = 1'b1;
                    next_state = S_IDLE;
                end
            endcase
        end else if (state != S_IDLE && to_cnt == TO_LAST) begin
            to_fire    = 1'b1;
            next_state = S_IDLE;
        end
    end

    // Prefix FSM, idle counter and timeout pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= next_state;
            timeout <= to_fire;
            if (rx_done || state == S_IDLE || to_fire) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    assign fifo_full = (count == FIFO_FULL);
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    // A full FIFO still takes a new event if the head leaves on the same edge.
    assign wr_en     = ev_push && (!fifo_full || pop);

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !wr_en) begin
                count <= count - CNT_W'(1);
            end
            if (ev_push && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are never visible while empty so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= ev_data;
        end
    end

    assign evt_code    = evt_valid ? mem[rd_ptr][9:2] : 8'h00;
    assign evt_ext     = evt_valid ? mem[rd_ptr][1]   : 1'b0;
    assign evt_release = evt_valid ? mem[rd_ptr][0]   : 1'b0;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with an expected-event queue.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic       overflow;
    logic       timeout;

    logic [9:0] exp_q[$];
    int tests_run = 0;
    int fail_cnt  = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_release(evt_release), .overflow(overflow),
        .timeout(timeout)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failed so far %0d", fail_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one byte strobe, returns at the negedge after it was sampled
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic expect_evt(input logic [7:0] code, input logic ext, input logic rel);
        exp_q.push_back({code, ext, rel});
    endtask

    // scoreboard: wait (bounded) for head, compare against queue, pop it
    task automatic pop_check(input string tag);
        int waited = 0;
        logic [9:0] exp;
        while (!evt_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!evt_valid) begin
            check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_extra"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {22'd0, evt_code, evt_ext, evt_release}, {22'd0, exp});
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
    endtask

    initial begin
        int to_pulses;
        int to_idx;

        // reset state
        #12;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_outs", {22'd0, evt_code, evt_ext, evt_release}, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_to", 32'(timeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // make then break of 1C, evt_valid one cycle after final byte
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b0);
        check("mk_latency", 32'(evt_valid), 32'd1);
        pop_check("mk_1c");
        send_byte(8'hF0);
        check("brk_prefix_noevt", 32'(evt_valid), 32'd0);
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b1);
        check("brk_latency", 32'(evt_valid), 32'd1);
        pop_check("brk_1c");

        // extended make and break
        send_byte(8'hE0);
        send_byte(8'h75);
        expect_evt(8'h75, 1'b1, 1'b0);
        pop_check("ext_mk");
        send_byte(8'hE0);
        send_byte(8'hF0);
        check("ext_brk_prefix_noevt", 32'(evt_valid), 32'd0);
        send_byte(8'h75);
        expect_evt(8'h75, 1'b1, 1'b1);
        pop_check("ext_brk");

        // full FIFO with simultaneous push and pop is accepted
        send_byte(8'h15); expect_evt(8'h15, 1'b0, 1'b0);
        send_byte(8'h16); expect_evt(8'h16, 1'b0, 1'b0);
        send_byte(8'h1E); expect_evt(8'h1E, 1'b0, 1'b0);
        send_byte(8'h26); expect_evt(8'h26, 1'b0, 1'b0);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = 8'h25;
        evt_ready = 1'b1;
        check("full_pp_head", {22'd0, evt_code, evt_ext, evt_release}, {22'd0, exp_q.pop_front()});
        expect_evt(8'h25, 1'b0, 1'b0);
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
        evt_ready = 1'b0;
        check("full_pp_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_check("full_pp_drain");
        check("full_pp_empty", 32'(evt_valid), 32'd0);

        // overflow: fifth event dropped while consumer stalls
        send_byte(8'h15); expect_evt(8'h15, 1'b0, 1'b0);
        send_byte(8'h16); expect_evt(8'h16, 1'b0, 1'b0);
        send_byte(8'h1E); expect_evt(8'h1E, 1'b0, 1'b0);
        send_byte(8'h26); expect_evt(8'h26, 1'b0, 1'b0);
        check("ovf_before", 32'(overflow), 32'd0);
        send_byte(8'h25);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_check("ovf_drain");
        check("ovf_empty", 32'(evt_valid), 32'd0);
        check("ovf_empty_code", 32'(evt_code), 32'd0);

        // pending prefix abandoned after idle period
        send_byte(8'hE0);
        to_pulses = 0;
        to_idx = 0;
        for (int k = 1; k <= 3 * TO; k++) begin
            @(negedge clk);
            if (timeout) begin
                to_pulses++;
                if (to_idx == 0) to_idx = k;
            end
        end
        check("to_pulses", 32'(to_pulses), 32'd1);
        check("to_window", 32'(to_idx >= TO - 1 && to_idx <= TO + 1), 32'd1);
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b0);
        pop_check("to_after");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // control bytes discarded and clear prefixes
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'hE0);
        send_byte(8'hFA);
        check("ctl_noevt", 32'(evt_valid), 32'd0);
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b0);
        pop_check("ctl_1c");
        check("ctl_single", 32'(evt_valid), 32'd0);

        // reset mid-sequence with events queued
        send_byte(8'h1C);
        send_byte(8'h5A);
        send_byte(8'hF0);
        check("pre_rst_valid", 32'(evt_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(evt_valid), 32'd0);
        check("arst_outs", {22'd0, evt_code, evt_ext, evt_release}, 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_to", 32'(timeout), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b0);
        pop_check("post_rst");
        check("post_rst_empty", 32'(evt_valid), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        // report
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
